// File: rtl/dual_alu_io_pkg.sv
// Shared types and pad map for the dual 4-bit ALU pad responder.
// ALU_PARITY_EN trades the counter MSB for a result parity bit.
package dual_alu_io_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SETTLE,
    COMMIT,
    HOLD
  } state_e;

  localparam int IN_A0_LSB   = 18;
  localparam int IN_B0_LSB   = 22;
  localparam int IN_A1_LSB   = 26;
  localparam int IN_B1_LSB   = 30;
  localparam int IN_SEL1_LSB = 34;
  localparam int IN_SEL2_LSB = 36;
  localparam int OUT_HI_LSB  = 4;
  localparam int OUT_LO_BIT  = 0;

  // Offsets inside the synchronized 20-bit vector
  localparam int IN_BASE = IN_A0_LSB;

  localparam logic [37:0] OEB_MASK =
    ~(38'h1 | (38'h3FFF << OUT_HI_LSB));

`ifdef ALU_PARITY_EN
  localparam int CTR_W = 3;
`else
  localparam int CTR_W = 4;
`endif

endpackage

// File: rtl/dual_alu_pad_responder_alu4_core.sv
// Combinational 4-bit ALU: add, sub (borrow in bit 4), and, xor.
module alu4_core
  import dual_alu_io_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  alu_op_e    i_sel,
  output logic [4:0] o_y
);

  always_comb begin
    o_y = '0;
    unique case (i_sel)
      ALU_ADD: o_y = {1'b0, i_a} + {1'b0, i_b};
      ALU_SUB: o_y = {1'b0, i_a} - {1'b0, i_b};
      ALU_AND: o_y = {1'b0, i_a & i_b};
      ALU_XOR: o_y = {1'b0, i_a ^ i_b};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/dual_alu_pad_responder.sv
// Pad-side responder: debounces operand pins, commits two ALU results.
// ALU_PARITY_EN puts result parity in W[13] and narrows the counter.
module dual_alu_pad_responder
  import dual_alu_io_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
)(
  input  logic        clock,
  input  logic        resetb,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  logic [19:0]      r_sync [SYNC_STAGES];
  logic [19:0]      w_s;
  state_e           r_state;
  logic [19:0]      r_cand;
  logic [7:0]       r_cnt;
  logic [4:0]       r_r0;
  logic [4:0]       r_r1;
  logic [CTR_W-1:0] r_ctr;
  logic             r_valid;
  logic [4:0]       w_y0;
  logic [4:0]       w_y1;
  logic             w_chg;
  logic             w_done;
  logic [14:0]      w_word;
  logic             w_unused;

  assign w_unused = ^io_in[IN_BASE-1:0];

  always_ff @(posedge clock) begin
    if (!resetb) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= io_in[37:IN_BASE];
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_chg  = (w_s != r_cand);
  assign w_done = (r_cnt == 8'(STABLE_CYCLES - 1));

  alu4_core u_alu0 (
    .i_a   (r_cand[IN_A0_LSB-IN_BASE +: 4]),
    .i_b   (r_cand[IN_B0_LSB-IN_BASE +: 4]),
    .i_sel (alu_op_e'(r_cand[IN_SEL1_LSB-IN_BASE +: 2])),
    .o_y   (w_y0)
  );

  alu4_core u_alu1 (
    .i_a   (r_cand[IN_A1_LSB-IN_BASE +: 4]),
    .i_b   (r_cand[IN_B1_LSB-IN_BASE +: 4]),
    .i_sel (alu_op_e'(r_cand[IN_SEL2_LSB-IN_BASE +: 2])),
    .o_y   (w_y1)
  );

`ifdef ALU_PARITY_EN
  logic r_par;

  always_ff @(posedge clock) begin
    if (!resetb)
      r_par <= 1'b0;
    else if (r_state == SETTLE && !w_chg && w_done)
      r_par <= ^{w_y1, w_y0};
  end

  assign w_word = {r_valid, r_par, r_ctr, r_r1, r_r0};
`else
  assign w_word = {r_valid, r_ctr, r_r1, r_r0};
`endif

  // Results latch on the edge that leaves SETTLE so valid rises with them
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state <= SETTLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_ctr   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        SETTLE: begin
          if (w_chg) begin
            r_cand  <= w_s;
            r_cnt   <= '0;
            r_valid <= 1'b0;
          end else if (w_done) begin
            r_state <= COMMIT;
            r_cnt   <= '0;
            r_r0    <= w_y0;
            r_r1    <= w_y1;
            r_ctr   <= r_ctr + 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        COMMIT, HOLD: begin
          if (w_chg) begin
            r_state <= SETTLE;
            r_cand  <= w_s;
            r_cnt   <= '0;
            r_valid <= 1'b0;
          end else begin
            r_state <= HOLD;
          end
        end
        default: r_state <= SETTLE;
      endcase
    end
  end

  always_comb begin
    io_out                       = '0;
    io_out[OUT_LO_BIT]           = w_word[0];
    io_out[OUT_HI_LSB +: 14]     = w_word[14:1];
  end

  assign io_oeb = OEB_MASK;

endmodule

// File: tb/tb_dual_alu_pad_responder.sv
// Scoreboard bench: valid edges predicted from pin-change timing.
// Honours ALU_PARITY_EN for the expected word layout.
module tb_dual_alu_pad_responder;

  localparam int SYNC = 2;
  localparam int STAB = 8;
  localparam logic [37:0] OEB_EXP =
    ~(38'h1 | (38'h3FFF << 4));
`ifdef ALU_PARITY_EN
  localparam int CTR_MOD = 8;
`else
  localparam int CTR_MOD = 16;
`endif

  typedef struct {
    bit          rise;
    int          cyc;
    logic [14:0] w;
  } ev_t;

  logic        clock  = 1'b0;
  logic        resetb = 1'b0;
  logic [37:0] io_in  = '0;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  ev_t         q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  logic        pv      = 1'b0;
  int          m_ctr   = 0;
  bit          m_valid = 1'b0;
  logic [14:0] m_last  = '0;
  logic [19:0] m_prev  = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dual_alu_pad_responder #(
    .STABLE_CYCLES (STAB),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  function automatic logic [4:0] ref_alu(
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] s);
    int r;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
    return 5'(r & 31);
  endfunction

  function automatic logic [14:0] ref_word(
    input logic [19:0] p, input int ctr);
    logic [4:0] r0;
    logic [4:0] r1;
    r0 = ref_alu(p[3:0], p[7:4], p[17:16]);
    r1 = ref_alu(p[11:8], p[15:12], p[19:18]);
`ifdef ALU_PARITY_EN
    return {1'b1, ^{r1, r0}, 3'(ctr), r1, r0};
`else
    return {1'b1, 4'(ctr), r1, r0};
`endif
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    io_in[17:0] = 18'($urandom);
  endtask

  task automatic do_reset(input int n);
    int t;
    t = cyc;
    resetb = 1'b0;
    io_in[37:18] = 20'($urandom);
    if (m_valid)
      q.push_back(ev_t'{1'b0, t + 1, 15'h0});
    m_valid = 1'b0;
    m_ctr   = 0;
    m_last  = '0;
    m_prev  = '0;
    repeat (n) tick();
    check("reset_io_out", 64'(io_out), 64'd0);
    check("reset_io_oeb", 64'(io_oeb), 64'(OEB_EXP));
  endtask

  // Pattern held d clocks commits only if it outlives STAB checks
  task automatic apply(input logic [19:0] p, input int d);
    int t;
    t = cyc;
    io_in[37:18] = p;
    if (m_valid)
      q.push_back(ev_t'{1'b0, t + SYNC + 1, {1'b0, m_last[13:0]}});
    m_valid = 1'b0;
    if (d > STAB) begin
      m_ctr   = (m_ctr + 1) % CTR_MOD;
      m_last  = ref_word(p, m_ctr);
      m_valid = 1'b1;
      q.push_back(ev_t'{1'b1, t + SYNC + STAB + 1, m_last});
    end
    m_prev = p;
    repeat (d) tick();
  endtask

  task automatic apply_zero(input int d);
    int t;
    t = cyc;
    io_in[37:18] = '0;
    m_ctr   = (m_ctr + 1) % CTR_MOD;
    m_last  = ref_word(20'h0, m_ctr);
    m_valid = 1'b1;
    q.push_back(ev_t'{1'b1, t + STAB, m_last});
    m_prev = '0;
    repeat (d) tick();
  endtask

  function automatic logic [19:0] new_pat();
    logic [19:0] p;
    do p = 20'($urandom); while (p == m_prev || p == 20'h0);
    return p;
  endfunction

  always @(negedge clock) begin
    logic [14:0] w;
    ev_t e;
    w = {io_out[17:4], io_out[0]};
    if (mon_en && w[14] !== pv) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid_edge: cyc %0d word %h expected none",
                 cyc, w);
      end else begin
        e = q.pop_front();
        if (e.rise !== w[14] || e.cyc != cyc || e.w !== w) begin
          n_fail++;
          $display("FAIL %s: cyc %0d word %h expected cyc %0d word %h",
                   e.rise ? "valid_rise" : "valid_fall",
                   cyc, w, e.cyc, e.w);
        end
      end
    end
    pv = w[14];
  end

  initial begin
    logic [19:0] p;
    logic [19:0] base;
    int t;
    int d;

    tick();
    do_reset(5);
    mon_en = 1'b1;
    resetb = 1'b1;

    apply(20'h00099, 20);
    apply(20'hDAF53, 20);

    base = m_prev;
    for (int k = 0; k < 10; k++) begin
      base[7:4] = base[7:4] + 4'd1;
      apply(base, 5);
    end
    base[7:4] = base[7:4] + 4'd1;
    apply(base, 20);

    apply(new_pat(), STAB);
    apply(new_pat(), STAB + 1);
    apply(new_pat(), 20);

    base = m_prev;
    apply(base ^ 20'h00010, 1);
    apply(base, 20);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0)
        d = $urandom_range(1, STAB);
      else
        d = $urandom_range(STAB + 1, STAB + 10);
      apply(new_pat(), d);
    end

    p = new_pat();
    t = cyc;
    io_in[37:18] = p;
    if (m_valid)
      q.push_back(ev_t'{1'b0, t + SYNC + 1, {1'b0, m_last[13:0]}});
    m_valid = 1'b0;
    m_prev  = p;
    repeat (SYNC + STAB - 1) tick();
    do_reset(1);
    resetb = 1'b1;
    apply(p, 20);

    do_reset(3);
    io_in[37:18] = '0;
    resetb = 1'b1;
    apply_zero(12);
    apply(new_pat(), 15);

    repeat (20) tick();
    check("events_pending", 64'(q.size()), 64'd0);
    check("io_oeb_const", 64'(io_oeb), 64'(OEB_EXP));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
